banked_memory_controller: RTL and testbench

//  Parametrised successor of the single-port memory controller. Separate write and read request

---
 rtl/mc_pkg.sv | 15 +
 rtl/mc_req_fifo.sv | 45 ++++
 rtl/banked_memory_controller.sv | 91 +++++++++
 tb/tb_banked_memory_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared request, opcode and pipe-stage types for banked_memory_controller.
package mc_pkg;
   localparam int MC_ADDR_W = 16;
   localparam int MC_DATA_W = 16;
   typedef enum logic {MC_OP_RD = 1'b0, MC_OP_WR = 1'b1} mc_op_e;
   typedef struct packed {
      logic [MC_ADDR_W-1:0] addr;
      logic [MC_DATA_W-1:0] data;
   } mc_req_t;
   typedef struct packed {
      logic    valid;
      mc_op_e  op;
      mc_req_t req;
   } mc_pipe_t;
endpackage

// File: rtl/mc_req_fifo.sv
// mc_req_fifo: sync request FIFO exposing its entries oldest-first with per-entry valid.
module mc_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push_i,
   input  logic [WIDTH-1:0]            din_i,
   input  logic                        pop_i,
   output logic [WIDTH-1:0]            head_o,
   output logic [$clog2(DEPTH):0]      count_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic [DEPTH-1:0][WIDTH-1:0] ent_o,
   output logic [DEPTH-1:0]            vld_o
);
   localparam int PW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0] rp_q, wp_q;
   logic [PW:0] cnt_q;
   always_ff @(posedge clk)
      if (push_i) mem_q[wp_q] <= din_i;
   always_ff @(posedge clk) begin
      if (reset) begin
         rp_q  <= '0;
         wp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= push_i ? wp_q + 1'b1 : wp_q;
         rp_q  <= pop_i ? rp_q + 1'b1 : rp_q;
         cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
      end
   end
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_o[i] = mem_q[rp_q + PW'(i)];
         vld_o[i] = (PW+1)'(i) < cnt_q;
      end
   end
   assign head_o  = mem_q[rp_q];
   assign count_o = cnt_q;
   assign full_o  = cnt_q == (PW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
endmodule

// File: rtl/banked_memory_controller.sv
// banked_memory_controller: dual-queue, bank-interleaved fixed-latency memory with tagged returns.
// Define MC_RAW_CHECK_EN to hold reads behind queued writes to the same address.
module banked_memory_controller import mc_pkg::*; #(
   parameter int ADDR_W         = MC_ADDR_W,
   parameter int DATA_W         = MC_DATA_W,
   parameter int NUM_BANKS      = 4,
   parameter int QUEUE_DEPTH    = 4,
   parameter int ACCESS_LATENCY = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_address,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              wr_ret_ack,
   output logic [ADDR_W-1:0] wr_ret_address,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_address,
   output logic              rd_ready,
   output logic              rd_ret_ack,
   output logic [ADDR_W-1:0] rd_ret_address,
   output logic [DATA_W-1:0] rd_ret_data
);
   localparam int BW = $clog2(NUM_BANKS);
   localparam int CW = $clog2(QUEUE_DEPTH) + 1;
   localparam int RW = $bits(mc_req_t);
   mc_req_t wr_in, rd_in, wr_head, rd_head;
   mc_req_t [QUEUE_DEPTH-1:0] wr_ent;
   logic [QUEUE_DEPTH-1:0][RW-1:0] unused_rd_ent;
   logic [QUEUE_DEPTH-1:0] wr_vld, unused_rd_vld;
   logic [CW-1:0] unused_wr_cnt, unused_rd_cnt;
   logic wr_full, rd_full, wr_empty, rd_empty;
   logic rd_elig, wr_elig, gnt_rd, gnt_wr, raw_hit, rd_prio_q;
   logic [NUM_BANKS-1:0] busy;
   mc_pipe_t pipe_q [ACCESS_LATENCY];
   mc_pipe_t done;
   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   assign wr_in    = '{addr: wr_address, data: wr_data};
   assign rd_in    = '{addr: rd_address, data: '0};
   assign wr_ready = !wr_full;
   assign rd_ready = !rd_full;
   mc_req_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(RW)) u_wr_q (
      .clk(clk), .reset(reset), .push_i(wr_en && wr_ready), .din_i(wr_in), .pop_i(gnt_wr),
      .head_o(wr_head), .count_o(unused_wr_cnt), .full_o(wr_full), .empty_o(wr_empty),
      .ent_o(wr_ent), .vld_o(wr_vld));
   mc_req_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(RW)) u_rd_q (
      .clk(clk), .reset(reset), .push_i(rd_en && rd_ready), .din_i(rd_in), .pop_i(gnt_rd),
      .head_o(rd_head), .count_o(unused_rd_cnt), .full_o(rd_full), .empty_o(rd_empty),
      .ent_o(unused_rd_ent), .vld_o(unused_rd_vld));
   // Stage i holds an op issued i+1 cycles ago; the last stage is the completing op.
   always_comb begin
      busy = '0;
      for (int i = 0; i < ACCESS_LATENCY-1; i++)
         if (pipe_q[i].valid) busy[pipe_q[i].req.addr[BW-1:0]] = 1'b1;
   end
`ifdef MC_RAW_CHECK_EN
   always_comb begin
      raw_hit = 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++)
         if (wr_vld[i] && wr_ent[i].addr == rd_head.addr) raw_hit = 1'b1;
   end
`else
   logic unused_raw;
   assign unused_raw = ^{wr_ent, wr_vld};
   assign raw_hit    = 1'b0;
`endif
   assign rd_elig = !rd_empty && !busy[rd_head.addr[BW-1:0]] && !raw_hit;
   assign wr_elig = !wr_empty && !busy[wr_head.addr[BW-1:0]];
   assign gnt_rd  = rd_elig && (rd_prio_q || !wr_elig);
   assign gnt_wr  = wr_elig && !gnt_rd;
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_prio_q <= 1'b1;
         for (int i = 0; i < ACCESS_LATENCY; i++) pipe_q[i] <= '0;
      end else begin
         rd_prio_q <= (gnt_rd || gnt_wr) ? gnt_wr : rd_prio_q;
         pipe_q[0] <= '{valid: gnt_rd || gnt_wr, op: gnt_wr ? MC_OP_WR : MC_OP_RD,
                        req: gnt_wr ? wr_head : rd_head};
         for (int i = 1; i < ACCESS_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end
   assign done = pipe_q[ACCESS_LATENCY-1];
   always_ff @(posedge clk)
      if (!reset && done.valid && done.op == MC_OP_WR) mem_q[done.req.addr] <= done.req.data;
   assign wr_ret_ack     = done.valid && done.op == MC_OP_WR;
   assign rd_ret_ack     = done.valid && done.op == MC_OP_RD;
   assign wr_ret_address = wr_ret_ack ? done.req.addr : '0;
   assign rd_ret_address = rd_ret_ack ? done.req.addr : '0;
   assign rd_ret_data    = rd_ret_ack ? mem_q[done.req.addr] : '0;
endmodule

// File: tb/tb_banked_memory_controller.sv
// tb_banked_memory_controller: directed tests with a cycle-level queue/bank-timing model.
module tb_banked_memory_controller;
   logic clk = 1'b0, reset = 1'b1;
   logic wr_en = 1'b0, rd_en = 1'b0;
   logic [15:0] wr_address = '0, wr_data = '0, rd_address = '0;
   logic wr_ready, rd_ready, wr_ret_ack, rd_ret_ack;
   logic [15:0] wr_ret_address, rd_ret_address, rd_ret_data;
   int total = 0, bad = 0, cyc = 0;
   banked_memory_controller dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
      .wr_ready(wr_ready), .wr_ret_ack(wr_ret_ack), .wr_ret_address(wr_ret_address),
      .rd_en(rd_en), .rd_address(rd_address), .rd_ready(rd_ready), .rd_ret_ack(rd_ret_ack),
      .rd_ret_address(rd_ret_address), .rd_ret_data(rd_ret_data));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {bit wr; logic [15:0] addr; logic [15:0] data;} op_t;
   typedef struct {int cyc; bit wr; logic [15:0] addr; logic [15:0] data;} ev_t;
   op_t mq_wr[$], mq_rd[$];
   op_t sched[int];
   logic [15:0] mmem[int];
   int bank_free[4];
   bit m_prio_rd = 1'b1, m_on = 1'b0;
   ev_t ev[$];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   // Model: queues of accepted requests, per-bank free cycle, completions keyed by cycle.
   always @(negedge clk) begin
      bit m_wrdy, m_rrdy, has, rd_ok, wr_ok;
      op_t o;
      if (m_on) begin
         m_wrdy = mq_wr.size() < 4;
         m_rrdy = mq_rd.size() < 4;
         chk("wr_ready", wr_ready, m_wrdy);
         chk("rd_ready", rd_ready, m_rrdy);
         has = sched.exists(cyc);
         if (has) o = sched[cyc];
         chk("wr_ret_ack", wr_ret_ack, has && o.wr);
         chk("rd_ret_ack", rd_ret_ack, has && !o.wr);
         if (has && o.wr) chk("wr_ret_address", wr_ret_address, o.addr);
         if (has && !o.wr) begin
            chk("rd_ret_address", rd_ret_address, o.addr);
            if (mmem.exists(int'(o.addr))) chk("rd_ret_data", rd_ret_data, mmem[int'(o.addr)]);
         end
         if (wr_ret_ack) ev.push_back('{cyc, 1'b1, wr_ret_address, 16'h0});
         if (rd_ret_ack) ev.push_back('{cyc, 1'b0, rd_ret_address, rd_ret_data});
         if (has) sched.delete(cyc);
         if (!reset) begin
            if (has && o.wr) mmem[int'(o.addr)] = o.data;
            rd_ok = mq_rd.size() > 0 && bank_free[mq_rd[0].addr[1:0]] <= cyc;
            wr_ok = mq_wr.size() > 0 && bank_free[mq_wr[0].addr[1:0]] <= cyc;
`ifdef MC_RAW_CHECK_EN
            if (rd_ok) foreach (mq_wr[i]) if (mq_wr[i].addr == mq_rd[0].addr) rd_ok = 1'b0;
`endif
            if (rd_ok || wr_ok) begin
               o = (rd_ok && (m_prio_rd || !wr_ok)) ? mq_rd.pop_front() : mq_wr.pop_front();
               bank_free[o.addr[1:0]] = cyc + 3;
               sched[cyc + 3] = o;
               m_prio_rd = o.wr;
            end
            if (wr_en && m_wrdy) mq_wr.push_back('{1'b1, wr_address, wr_data});
            if (rd_en && m_rrdy) mq_rd.push_back('{1'b0, rd_address, 16'h0});
         end
      end
      if (reset) begin
         mq_wr.delete();
         mq_rd.delete();
         sched.delete();
         foreach (bank_free[i]) bank_free[i] = 0;
         m_prio_rd = 1'b1;
         m_on = 1'b1;
      end
   end
   function automatic int find_ev(input bit wr, input logic [15:0] a, input int from);
      foreach (ev[i]) if (ev[i].wr == wr && ev[i].addr == a && ev[i].cyc >= from) return i;
      return -1;
   endfunction
   function automatic int ev_cyc(input int k);
      return k < 0 ? -1 : ev[k].cyc;
   endfunction
   function automatic logic [15:0] ev_data(input int k);
      return k < 0 ? 16'hxxxx : ev[k].data;
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input bit we, input logic [15:0] wa, input logic [15:0] wd,
                        input bit re, input logic [15:0] ra);
      wr_en = we; wr_address = wa; wr_data = wd;
      rd_en = re; rd_address = ra;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) step();
   endtask
   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask
   bit rdy_tab[10] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 0};
   int acc_i[7] = '{0, 1, 2, 3, 4, 5, 8};
   int acc_c[7] = '{4, 7, 10, 13, 16, 19, 22};
   int drop_i[3] = '{6, 7, 9};
   initial begin
      int t, k, n;
      idle(2);
      reset = 1'b0;
      chk("rst wr_ready", wr_ready, 1);
      chk("rst rd_ready", rd_ready, 1);
      chk("rst wr_ret_ack", wr_ret_ack, 0);
      chk("rst rd_ret_ack", rd_ret_ack, 0);
      t = cyc; drive(1, 16'h0005, 16'hBEEF, 0, 0); idle(8);
      chk("t1 wr ack cycle", ev_cyc(find_ev(1, 16'h0005, t)), t + 4);
      t = cyc; drive(0, 0, 0, 1, 16'h0005); idle(8);
      k = find_ev(0, 16'h0005, t);
      chk("t1 rd ack cycle", ev_cyc(k), t + 4);
      chk("t1 rd data", ev_data(k), 16'hBEEF);
      t = cyc;
      for (int i = 0; i < 10; i++) begin
         chk("t2 wr_ready", wr_ready, rdy_tab[i]);
         drive(1, 16'(4 * i), 16'(16'h0100 + i), 0, 0);
      end
      idle(25);
      for (int i = 0; i < 7; i++)
         chk("t2 accepted ack cycle", ev_cyc(find_ev(1, 16'(4 * acc_i[i]), t)), t + acc_c[i]);
      for (int i = 0; i < 3; i++)
         chk("t2 dropped never acked", find_ev(1, 16'(4 * drop_i[i]), t), -1);
      t = cyc;
      for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 16'(i));
      idle(10);
      for (int i = 0; i < 8; i++)
         chk("t3 rd ack cycle", ev_cyc(find_ev(0, 16'(i), t)), t + 4 + i);
      chk("t3 rd data 0", ev_data(find_ev(0, 16'h0000, t)), 16'h0100);
      chk("t3 rd data 5", ev_data(find_ev(0, 16'h0005, t)), 16'hBEEF);
      do_reset();
      t = cyc; drive(1, 16'h0002, 16'h7777, 1, 16'h0001); idle(10);
      chk("t4 rd ack cycle", ev_cyc(find_ev(0, 16'h0001, t)), t + 4);
      chk("t4 wr ack cycle", ev_cyc(find_ev(1, 16'h0002, t)), t + 5);
      drive(1, 16'h0010, 16'h5555, 0, 0); idle(8);
      do_reset();
      t = cyc;
      drive(1, 16'h0000, 16'hAAAA, 0, 0);
      drive(1, 16'h0010, 16'h1234, 1, 16'h0010);
      idle(15);
      chk("t5 wr0 ack cycle", ev_cyc(find_ev(1, 16'h0000, t)), t + 4);
      k = find_ev(0, 16'h0010, t);
`ifdef MC_RAW_CHECK_EN
      chk("t5 wr10 ack cycle", ev_cyc(find_ev(1, 16'h0010, t)), t + 7);
      chk("t5 rd ack cycle", ev_cyc(k), t + 10);
      chk("t5 rd data", ev_data(k), 16'h1234);
`else
      chk("t5 wr10 ack cycle", ev_cyc(find_ev(1, 16'h0010, t)), t + 10);
      chk("t5 rd ack cycle", ev_cyc(k), t + 7);
      chk("t5 rd data", ev_data(k), 16'h5555);
`endif
      drive(1, 16'h0021, 16'h1111, 0, 0);
      drive(1, 16'h0025, 16'h5555, 0, 0);
      drive(1, 16'h0026, 16'h6666, 0, 0);
      idle(12);
      do_reset();
      t = cyc;
      drive(1, 16'h0021, 16'hD1D1, 1, 16'h0022);
      drive(1, 16'h0025, 16'hD5D5, 1, 16'h0023);
      drive(1, 16'h0026, 16'hD6D6, 1, 16'h0027);
      do_reset();
      chk("t6 wr_ready after reset", wr_ready, 1);
      chk("t6 rd_ready after reset", rd_ready, 1);
      idle(10);
      n = 0;
      foreach (ev[i]) if (ev[i].cyc >= t + 3) n++;
      chk("t6 acks after reset", n, 0);
      t = cyc;
      drive(0, 0, 0, 1, 16'h0021);
      drive(0, 0, 0, 1, 16'h0025);
      drive(0, 0, 0, 1, 16'h0026);
      idle(8);
      chk("t6 mem 0x21", ev_data(find_ev(0, 16'h0021, t)), 16'h1111);
      chk("t6 mem 0x25", ev_data(find_ev(0, 16'h0025, t)), 16'h5555);
      chk("t6 mem 0x26", ev_data(find_ev(0, 16'h0026, t)), 16'h6666);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
